mux2x32_reg: RTL and testbench
==============================

Name: mux2x32_reg

Overview:
- Registered 2-to-1 word multiplexer for the CPU datapath.
- Selects operand A or B with select S, then registers the chosen word on the rising clock edge.
- A combinational copy of the selected word is also exported for same-cycle consumers, e.g. forwarding paths.
- Sits between register-file/immediate sources and downstream ALU/PC logic.

Parameters:
- WIDTH, 32, data width of A, B, Y and Y_COMB in bits.
- RESET_VAL, 32'h0000_0000, value loaded into Y on reset; width equals WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- A  input  WIDTH  data input 0.
- B  input  WIDTH  data input 1.
- S  input  1  select: 0 selects A, 1 selects B.
- EN  input  1  load enable for the output register.
- IN_VALID  input  1  marks A/B/S as valid this cycle.
- Y_COMB  output  WIDTH  combinational selected word, no latency.
- Y  output  WIDTH  registered selected word.
- OUT_VALID  output  1  Y holds a word captured from a valid input.

Behaviour:
- Select encoding: Y_COMB = (S == 0) ? A : B.
  - Pure combinational logic.
  - Bit-exact, no width change, no sign or zero manipulation.
- Y_COMB follows input changes in the same cycle and is unaffected by RST, EN or IN_VALID.
- Y register, evaluated in priority order at each rising CLK edge:
  - RST = 1: Y <= RESET_VAL and OUT_VALID <= 0, regardless of EN or IN_VALID.
  - Else if EN = 1 and IN_VALID = 1: Y <= Y_COMB and OUT_VALID <= 1.
  - Else if EN = 1 and IN_VALID = 0: Y holds its value and OUT_VALID <= 0.
  - Else (EN = 0): Y and OUT_VALID both hold.
- Latency: Y reflects the select decision one clock after capture. Y_COMB has zero latency.
- S changing between edges: only the value present at the capturing edge matters. There is no glitch filtering on Y_COMB.
- Reset mid-stream: a capture coinciding with RST is discarded. The first capture after RST deasserts is the first cycle with RST = 0, EN = 1 and IN_VALID = 1.
- Power-up before the first reset: Y and OUT_VALID are undefined. The bench must apply RST for at least one edge.
- Unknown inputs: X or Z on S propagates X to Y_COMB. No special handling.
- No handshake back-pressure: the block always accepts input when EN = 1.

Decomposition:
- Shared package holds:
  - constant DATA_W = 32;
  - select constants SEL_A = 1'b0 and SEL_B = 1'b1;
  - the default reset word.
- One sub-module: mux2x32_core, a purely combinational WIDTH-bit 2:1 mux (A, B, S -> Y).
- mux2x32_reg instantiates the core and adds the enable/valid register stage.

Test Plan:
- Reset: RST = 1 for 2 cycles with A = 32'h8b, B = 32'h5f, S = 1, EN = 1, IN_VALID = 1.
  - Required: Y = 32'h0, OUT_VALID = 0.
  - Required: Y_COMB = 32'h5f throughout.
- Select B: release RST with A = 32'h8b, B = 32'h5f, S = 1, EN = 1, IN_VALID = 1.
  - Required: Y_COMB = 32'h5f immediately.
  - Required: Y = 32'h5f and OUT_VALID = 1 after the next edge.
- Select A: switch S to 0, other inputs unchanged.
  - Required: Y_COMB = 32'h8b in the same cycle.
  - Required: Y = 32'h8b one edge later.
- Enable hold: EN = 0, S toggles 0 -> 1, A = 32'hFFFF_FFFF, B = 32'h0.
  - Required: Y_COMB tracks the inputs (FFFF_FFFF, then 0).
  - Required: Y stays 32'h8b and OUT_VALID stays 1.
- Valid drop: EN = 1, IN_VALID = 0, S = 1, B = 32'hDEAD_BEEF.
  - Required: Y holds the prior value and OUT_VALID = 0 after the edge.
  - Then IN_VALID = 1: required Y = 32'hDEAD_BEEF and OUT_VALID = 1.
- Reset priority: in one cycle assert RST = 1, EN = 1, IN_VALID = 1, S = 0, A = 32'h1234_5678.
  - Required: Y = 32'h0 and OUT_VALID = 0 after the edge.
  - Required: Y_COMB = 32'h1234_5678.

Source files
------------

// File: rtl/mux2x32_reg_pkg.sv
// Shared constants for the registered 2:1 word multiplexer.
package mux2x32_reg_pkg;

    // Native datapath width.
    localparam int DATA_W = 32;

    // Select encoding: 0 routes operand A, 1 routes operand B.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Word loaded into the output register on reset.
    localparam logic [DATA_W-1:0] RESET_WORD = 32'h0000_0000;

endpackage : mux2x32_reg_pkg

// File: rtl/mux2x32_core.sv
// Purely combinational WIDTH-bit 2:1 multiplexer, bit-exact, no latency.
module mux2x32_core
    import mux2x32_reg_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    output logic [WIDTH-1:0] Y
);

    // Per-bit selection; an unknown select simply propagates through the operator.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign Y[gi] = (S == SEL_A) ? A[gi] : B[gi];
        end
    endgenerate

endmodule : mux2x32_core

// File: rtl/mux2x32_reg.sv
// Registered 2:1 word multiplexer with load enable and valid tracking.
// Y_COMB is the raw mux output for same-cycle consumers such as forwarding;
// Y / OUT_VALID are the registered copy, one clock behind the capturing edge.
module mux2x32_reg
    import mux2x32_reg_pkg::*;
#(
    parameter int               WIDTH     = DATA_W,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_WORD)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    input  logic             EN,
    input  logic             IN_VALID,
    output logic [WIDTH-1:0] Y_COMB,
    output logic [WIDTH-1:0] Y,
    output logic             OUT_VALID
);

    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] r_y;
    logic             r_valid;

    mux2x32_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .A (A),
        .B (B),
        .S (S),
        .Y (w_sel)
    );

    // Output stage: reset wins; with EN set, valid follows IN_VALID and data
    // loads only on a valid cycle; with EN clear everything holds.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_y     <= RESET_VAL;
            r_valid <= 1'b0;
        end else if (EN) begin
            if (IN_VALID) begin
                r_y <= w_sel;
            end
            r_valid <= IN_VALID;
        end
    end

    assign Y_COMB    = w_sel;
    assign Y         = r_y;
    assign OUT_VALID = r_valid;

endmodule : mux2x32_reg

// File: tb/tb_mux2x32_reg.sv
// Self-checking bench for mux2x32_reg: directed plan followed by random traffic
// compared against a behavioural model of the selection and capture rules.
module tb_mux2x32_reg;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] A;
    logic [31:0] B;
    logic        S;
    logic        EN;
    logic        IN_VALID;
    logic [31:0] Y_COMB;
    logic [31:0] Y;
    logic        OUT_VALID;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state of the output register.
    logic [31:0] m_y;
    logic        m_valid;

    mux2x32_reg dut (
        .CLK       (CLK),
        .RST       (RST),
        .A         (A),
        .B         (B),
        .S         (S),
        .EN        (EN),
        .IN_VALID  (IN_VALID),
        .Y_COMB    (Y_COMB),
        .Y         (Y),
        .OUT_VALID (OUT_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected combinational word from the select rule.
    function automatic logic [31:0] pick(input logic [31:0] a, input logic [31:0] b, input logic s);
        return s ? b : a;
    endfunction

    // One clock of traffic: drive, check Y_COMB (optionally after a mid-cycle
    // select flip), take the edge, advance the model, check the register.
    task automatic cycle(input string tag, input logic rst, input logic [31:0] a,
                         input logic [31:0] b, input logic s, input logic en,
                         input logic iv, input logic flip);
        RST = rst; A = a; B = b; S = s; EN = en; IN_VALID = iv;
        #1;
        check({tag, ".ycomb"}, Y_COMB, pick(A, B, S));
        if (flip) begin
            S = ~S;
            #1;
            check({tag, ".ycomb_flip"}, Y_COMB, pick(A, B, S));
        end
        @(posedge CLK);
        if (RST) begin
            m_y = 32'h0; m_valid = 1'b0;
        end else if (EN && IN_VALID) begin
            m_y = pick(A, B, S); m_valid = 1'b1;
        end else if (EN) begin
            m_valid = 1'b0;
        end
        #1;
        check({tag, ".y"}, Y, m_y);
        check({tag, ".valid"}, {31'h0, OUT_VALID}, {31'h0, m_valid});
        $display("txn %-10s rst=%0d s=%0d en=%0d iv=%0d a=%h b=%h -> y=%h v=%0d",
                 tag, RST, S, EN, IN_VALID, A, B, Y, OUT_VALID);
    endtask

    initial begin
        m_y = 32'h0; m_valid = 1'b0;

        // Reset held two edges with a capture attempt present.
        cycle("reset0", 1'b1, 32'h8b, 32'h5f, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("reset1", 1'b1, 32'h8b, 32'h5f, 1'b1, 1'b1, 1'b1, 1'b0);
        check("reset.y_const", Y, 32'h0);
        // Select B, then A.
        cycle("selB", 1'b0, 32'h8b, 32'h5f, 1'b1, 1'b1, 1'b1, 1'b0);
        check("selB.y_const", Y, 32'h5f);
        cycle("selA", 1'b0, 32'h8b, 32'h5f, 1'b0, 1'b1, 1'b1, 1'b0);
        check("selA.y_const", Y, 32'h8b);
        // Enable low: comb tracks, register holds.
        cycle("hold0", 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("hold1", 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("hold.y_const", Y, 32'h8b);
        check("hold.valid_const", {31'h0, OUT_VALID}, 32'h1);
        // Valid drop then recapture.
        cycle("vdrop", 1'b0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0);
        check("vdrop.valid_const", {31'h0, OUT_VALID}, 32'h0);
        cycle("vback", 1'b0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b0);
        check("vback.y_const", Y, 32'hDEAD_BEEF);
        // Reset beats a simultaneous capture.
        cycle("rstprio", 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 1'b0);
        check("rstprio.ycomb", Y_COMB, 32'h1234_5678);
        check("rstprio.y_const", Y, 32'h0);
        // Mid-cycle select change: only the value at the edge is captured.
        cycle("flip", 1'b0, 32'hA5A5_0001, 32'h5A5A_0002, 1'b0, 1'b1, 1'b1, 1'b1);
        check("flip.y_const", Y, 32'h5A5A_0002);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cycle("rand", ($urandom_range(0, 15) == 0), $urandom, $urandom,
                  1'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux2x32_reg
